ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/alu.sv | 34 +++
 rtl/ex_stage.sv | 148 ++++++++++++++
 tb/tb_ex_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 pipeline: ALU ops, branch conditions,
// forwarding selects and writeback result source.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_PASS = 4'b1010
    } alu_op_e;

    // Branch conditions match RISC-V funct3.
    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_cond_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

endpackage

// File: rtl/alu.sv
// Purely combinational integer ALU; unknown op codes produce zero.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      op_i,
    output logic [XLEN-1:0] y_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            ALU_SLL:  y_o = a_i << shamt;
            ALU_SRL:  y_o = a_i >> shamt;
            ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
            ALU_PASS: y_o = b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM
// pipeline register with flush-over-stall priority.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic [XLEN-1:0] rs1_data_e,
    input  logic [XLEN-1:0] rs2_data_e,
    input  logic [XLEN-1:0] immediate_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] pc_plus_4_e,
    input  logic [4:0]      rd_e,
    input  logic            regwrite_e,
    input  logic            memwrite_e,
    input  logic            jump_e,
    input  logic            branch_e,
    input  logic            alu_src_e,
    input  logic            jalr_e,
    input  logic [1:0]      result_src_e,
    input  logic [3:0]      alu_control_e,
    input  logic [2:0]      branch_control_e,
    input  logic [1:0]      forward_a_e,
    input  logic [1:0]      forward_b_e,
    input  logic [XLEN-1:0] writeback_data_w,
    output logic            pc_src_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [XLEN-1:0] pc_plus_4_m,
    output logic [4:0]      rd_m,
    output logic            regwrite_m,
    output logic            memwrite_m,
    output logic [1:0]      result_src_m
);

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_y, jalr_sum;
    logic            eq, lt, ltu, taken;

    // Code 11 is unused and falls back to the register file value.
    always_comb begin
        case (forward_a_e)
            FWD_WB:  src_a = writeback_data_w;
            FWD_MEM: src_a = alu_result_m;
            default: src_a = rs1_data_e;
        endcase
        case (forward_b_e)
            FWD_WB:  fwd_b = writeback_data_w;
            FWD_MEM: fwd_b = alu_result_m;
            default: fwd_b = rs2_data_e;
        endcase
    end

    assign src_b = alu_src_e ? immediate_e : fwd_b;

    alu #(.XLEN(XLEN)) u_alu (
        .a_i  (src_a),
        .b_i  (src_b),
        .op_i (alu_control_e),
        .y_o  (alu_y)
    );

    assign eq  = (src_a == fwd_b);
    assign lt  = ($signed(src_a) < $signed(fwd_b));
    assign ltu = (src_a < fwd_b);

    always_comb begin
        case (branch_control_e)
            BR_EQ:   taken = eq;
            BR_NE:   taken = !eq;
            BR_LT:   taken = lt;
            BR_GE:   taken = !lt;
            BR_LTU:  taken = ltu;
            BR_GEU:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    // Redirect is resolved here unconditionally; the hazard unit gates it.
    assign jalr_sum    = src_a + immediate_e;
    assign pc_src_e    = jump_e | (branch_e & taken);
    assign pc_target_e = jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : pc_e + immediate_e;

    logic [XLEN-1:0] alu_q, alu_d, wd_q, wd_d, pc4_q, pc4_d;
    logic [4:0]      rd_q, rd_d;
    logic            regw_q, regw_d, memw_q, memw_d;
    logic [1:0]      rsrc_q, rsrc_d;

    always_comb begin
        alu_d  = alu_y;
        wd_d   = fwd_b;
        pc4_d  = pc_plus_4_e;
        rd_d   = rd_e;
        regw_d = regwrite_e;
        memw_d = memwrite_e;
        rsrc_d = result_src_e;
        if (flush_e) begin
            alu_d  = '0;
            wd_d   = '0;
            pc4_d  = '0;
            rd_d   = '0;
            regw_d = 1'b0;
            memw_d = 1'b0;
            rsrc_d = RES_ALU;
        end else if (stall_e) begin
            alu_d  = alu_q;
            wd_d   = wd_q;
            pc4_d  = pc4_q;
            rd_d   = rd_q;
            regw_d = regw_q;
            memw_d = memw_q;
            rsrc_d = rsrc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_q  <= '0;
            wd_q   <= '0;
            pc4_q  <= '0;
            rd_q   <= '0;
            regw_q <= 1'b0;
            memw_q <= 1'b0;
            rsrc_q <= '0;
        end else begin
            alu_q  <= alu_d;
            wd_q   <= wd_d;
            pc4_q  <= pc4_d;
            rd_q   <= rd_d;
            regw_q <= regw_d;
            memw_q <= memw_d;
            rsrc_q <= rsrc_d;
        end
    end

    assign alu_result_m = alu_q;
    assign write_data_m = wd_q;
    assign pc_plus_4_m  = pc4_q;
    assign rd_m         = rd_q;
    assign regwrite_m   = regw_q;
    assign memwrite_m   = memw_q;
    assign result_src_m = rsrc_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver queues hand-computed expectations,
// a negedge monitor retires them when their cycle comes due.
module tb_ex_stage;

    logic        clk = 0, reset = 1, stall_e, flush_e;
    logic [31:0] rs1_data_e, rs2_data_e, immediate_e, pc_e, pc_plus_4_e, writeback_data_w;
    logic [4:0]  rd_e;
    logic        regwrite_e, memwrite_e, jump_e, branch_e, alu_src_e, jalr_e;
    logic [1:0]  result_src_e, forward_a_e, forward_b_e;
    logic [3:0]  alu_control_e;
    logic [2:0]  branch_control_e;
    logic        pc_src_e, regwrite_m, memwrite_m;
    logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus_4_m;
    logic [4:0]  rd_m;
    logic [1:0]  result_src_m;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
        .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e), .immediate_e(immediate_e),
        .pc_e(pc_e), .pc_plus_4_e(pc_plus_4_e), .rd_e(rd_e),
        .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .jump_e(jump_e),
        .branch_e(branch_e), .alu_src_e(alu_src_e), .jalr_e(jalr_e),
        .result_src_e(result_src_e), .alu_control_e(alu_control_e),
        .branch_control_e(branch_control_e), .forward_a_e(forward_a_e),
        .forward_b_e(forward_b_e), .writeback_data_w(writeback_data_w),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .pc_plus_4_m(pc_plus_4_m), .rd_m(rd_m),
        .regwrite_m(regwrite_m), .memwrite_m(memwrite_m), .result_src_m(result_src_m)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_reg;
        int          due;
        string       name;
        logic [31:0] alu, wd, pc4, tgt;
        logic [4:0]  rd;
        logic        regw, memw, pcs;
        logic [1:0]  rs;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_c(input string nm, input logic pcs, input logic [31:0] tgt);
        exp_t e;
        e = '{is_reg: 0, due: cyc, name: nm, alu: 0, wd: 0, pc4: 0, tgt: tgt,
              rd: 0, regw: 0, memw: 0, pcs: pcs, rs: 0};
        q.push_back(e);
    endtask

    task automatic expect_r(input string nm, input logic [31:0] alu, input logic [31:0] wd,
                            input logic [31:0] pc4, input logic [4:0] rd, input logic regw,
                            input logic memw, input logic [1:0] rs);
        exp_t e;
        e = '{is_reg: 1, due: cyc + 1, name: nm, alu: alu, wd: wd, pc4: pc4, tgt: 0,
              rd: rd, regw: regw, memw: memw, pcs: 0, rs: rs};
        q.push_back(e);
    endtask

    // Monitor: retire every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t it;
            it = q.pop_front();
            if (it.is_reg) begin
                chk({it.name, ".alu_result_m"}, alu_result_m, it.alu);
                chk({it.name, ".write_data_m"}, write_data_m, it.wd);
                chk({it.name, ".pc_plus_4_m"}, pc_plus_4_m, it.pc4);
                chk({it.name, ".rd_m"}, 32'(rd_m), 32'(it.rd));
                chk({it.name, ".regwrite_m"}, 32'(regwrite_m), 32'(it.regw));
                chk({it.name, ".memwrite_m"}, 32'(memwrite_m), 32'(it.memw));
                chk({it.name, ".result_src_m"}, 32'(result_src_m), 32'(it.rs));
            end else begin
                chk({it.name, ".pc_src_e"}, 32'(pc_src_e), 32'(it.pcs));
                chk({it.name, ".pc_target_e"}, pc_target_e, it.tgt);
            end
        end
    end

    task automatic defaults();
        stall_e = 0; flush_e = 0; rs1_data_e = 0; rs2_data_e = 0; immediate_e = 0;
        pc_e = 0; pc_plus_4_e = 0; writeback_data_w = 0; rd_e = 0;
        regwrite_e = 0; memwrite_e = 0; jump_e = 0; branch_e = 0; alu_src_e = 0; jalr_e = 0;
        result_src_e = 0; alu_control_e = 0; branch_control_e = 3'b010;
        forward_a_e = 0; forward_b_e = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".alu_result_m"}, alu_result_m, 0);
        chk({nm, ".write_data_m"}, write_data_m, 0);
        chk({nm, ".pc_plus_4_m"}, pc_plus_4_m, 0);
        chk({nm, ".rd_m"}, 32'(rd_m), 0);
        chk({nm, ".regwrite_m"}, 32'(regwrite_m), 0);
        chk({nm, ".memwrite_m"}, 32'(memwrite_m), 0);
        chk({nm, ".result_src_m"}, 32'(result_src_m), 0);
    endtask

    initial begin
        defaults();
        reset = 1;
        tick(); tick();
        check_zero("reset_state");
        reset = 0;

        defaults(); rs1_data_e = 5; immediate_e = 7; alu_src_e = 1; rs2_data_e = 32'h55;
        pc_e = 32'h40; pc_plus_4_e = 32'h44; rd_e = 3; regwrite_e = 1;
        expect_c("add", 0, 32'h47); expect_r("add", 12, 32'h55, 32'h44, 3, 1, 0, 0); tick();

        defaults(); rs2_data_e = 1; alu_control_e = 4'b0001; rd_e = 4; regwrite_e = 1;
        pc_e = 32'h44; pc_plus_4_e = 32'h48;
        expect_c("sub", 0, 32'h44); expect_r("sub_wrap", 32'hFFFFFFFF, 1, 32'h48, 4, 1, 0, 0); tick();

        defaults(); rs1_data_e = 32'h80000000; rs2_data_e = 32'h24; alu_control_e = 4'b1001;
        expect_r("sra", 32'hF8000000, 32'h24, 0, 0, 0, 0, 0); tick();

        defaults(); immediate_e = 32'h10; alu_src_e = 1; alu_control_e = 4'b1010; rd_e = 6; regwrite_e = 1;
        expect_c("pass", 0, 32'h10); expect_r("pass_b", 32'h10, 0, 0, 6, 1, 0, 0); tick();

        defaults(); forward_a_e = 2'b10; rs2_data_e = 1; rd_e = 7; regwrite_e = 1;
        expect_r("fwd_a_mem", 32'h11, 1, 0, 7, 1, 0, 0); tick();

        defaults(); forward_b_e = 2'b01; writeback_data_w = 32'hABCD; rs1_data_e = 2;
        rs2_data_e = 32'h999; memwrite_e = 1;
        expect_r("fwd_b_wb", 32'hABCF, 32'hABCD, 0, 0, 0, 1, 0); tick();

        defaults(); forward_a_e = 2'b11; writeback_data_w = 5; rs1_data_e = 9; immediate_e = 1; alu_src_e = 1;
        expect_c("fwd_a_11", 0, 1); expect_r("fwd_a_11", 10, 0, 0, 0, 0, 0, 0); tick();

        defaults(); rs1_data_e = 32'hFFFFFFFF; rs2_data_e = 1; branch_e = 1; branch_control_e = 3'b100;
        pc_e = 32'h100; immediate_e = 32'hFFFFFFF8; alu_control_e = 4'b0001;
        expect_c("blt", 1, 32'hF8); expect_r("blt", 32'hFFFFFFFE, 1, 0, 0, 0, 0, 0); tick();
        branch_control_e = 3'b110; expect_c("bltu", 0, 32'hF8); tick();
        branch_control_e = 3'b101; expect_c("bge", 0, 32'hF8); tick();
        branch_control_e = 3'b111; expect_c("bgeu", 1, 32'hF8); tick();

        defaults(); rs1_data_e = 7; rs2_data_e = 7; branch_e = 1; branch_control_e = 3'b000;
        pc_e = 32'h20; immediate_e = 32'h10; alu_control_e = 4'b0100;
        expect_c("beq", 1, 32'h30); expect_r("xor", 0, 7, 0, 0, 0, 0, 0); tick();
        branch_control_e = 3'b001; alu_control_e = 4'b0011;
        expect_c("bne", 0, 32'h30); expect_r("or", 7, 7, 0, 0, 0, 0, 0); tick();
        branch_control_e = 3'b010; expect_c("br_010", 0, 32'h30); tick();
        branch_control_e = 3'b000; branch_e = 0; alu_control_e = 4'b0010;
        expect_c("beq_nobranch", 0, 32'h30); expect_r("and", 7, 7, 0, 0, 0, 0, 0); tick();

        defaults(); rs1_data_e = 32'h203; jalr_e = 1; jump_e = 1; pc_e = 32'h300; pc_plus_4_e = 32'h304;
        alu_src_e = 1; result_src_e = 2'b10; rd_e = 1; regwrite_e = 1;
        expect_c("jalr", 1, 32'h202); expect_r("jalr", 32'h203, 0, 32'h304, 1, 1, 0, 2); tick();

        defaults(); rs1_data_e = 32'hFFFFFFFE; rs2_data_e = 3; alu_control_e = 4'b0101;
        expect_r("slt", 1, 3, 0, 0, 0, 0, 0); tick();
        alu_control_e = 4'b0110; expect_r("sltu", 0, 3, 0, 0, 0, 0, 0); tick();
        defaults(); rs1_data_e = 1; rs2_data_e = 32'h21; alu_control_e = 4'b0111;
        expect_r("sll_b40", 2, 32'h21, 0, 0, 0, 0, 0); tick();
        defaults(); rs1_data_e = 32'h80000000; rs2_data_e = 4; alu_control_e = 4'b1000;
        expect_r("srl", 32'h08000000, 4, 0, 0, 0, 0, 0); tick();
        defaults(); rs1_data_e = 5; rs2_data_e = 6; alu_control_e = 4'b1111;
        expect_r("bad_op", 0, 6, 0, 0, 0, 0, 0); tick();

        defaults(); rs1_data_e = 32'h30; immediate_e = 3; alu_src_e = 1; rs2_data_e = 32'h77;
        pc_plus_4_e = 32'h88; rd_e = 5; regwrite_e = 1; memwrite_e = 1; result_src_e = 2'b01;
        expect_r("pre_stall", 32'h33, 32'h77, 32'h88, 5, 1, 1, 1); tick();
        stall_e = 1; rs1_data_e = 32'h999; rd_e = 9; regwrite_e = 0; pc_plus_4_e = 32'h123;
        for (int i = 0; i < 3; i++) begin
            expect_r("stall_hold", 32'h33, 32'h77, 32'h88, 5, 1, 1, 1); tick();
        end
        flush_e = 1; regwrite_e = 1;
        expect_r("stall_flush", 0, 0, 0, 0, 0, 0, 0); tick();

        defaults(); rs1_data_e = 5; immediate_e = 7; alu_src_e = 1; rd_e = 3; regwrite_e = 1;
        expect_r("post_flush", 12, 0, 0, 3, 1, 0, 0); tick();
        @(negedge clk); #1;
        reset = 1; #1;
        check_zero("async_reset");
        reset = 0; #1;
        expect_r("resume", 12, 0, 0, 3, 1, 0, 0); tick();

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        chk("scoreboard_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
